noc_local_inject_arbiter: RTL and testbench
===========================================

# noc_local_inject_arbiter

Packet-level round-robin arbiter that shares one NoC router local injection port (valid/ready/flit/is_header/is_tail sender interface) between several local requesters, e.g. multiple test nodes or DMA engines on one tile. It selects a requester on a header flit and locks the port to that requester until its tail flit is accepted. Flits from different packets never interleave. The block sits between the requesters and the router local input, with a zero-cycle datapath and a registered arbitration state.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- PTR_W, 2, width of owner/pointer registers; must satisfy 2^PTR_W >= NUM_REQ
- noc_clk  in  1  clock, all state on rising edge
- noc_rst  in  1  reset; one clock; reset is synchronous and active-high
- req_valid  in  NUM_REQ  per-requester flit valid
- req_ready  out  NUM_REQ  per-requester flit accepted/drained
- req_flit  in  NUM_REQ*`Noc_Data_Width  flattened flits; requester i occupies bits [i*W +: W]
- req_is_header  in  NUM_REQ  flit is packet header
- req_is_tail  in  NUM_REQ  flit is packet tail
- out_valid  out  1  to router local port
- out_ready  in  1  from router local port
- out_flit  out  `Noc_Data_Width  selected flit
- out_is_header  out  1  selected header flag
- out_is_tail  out  1  selected tail flag
- grant  out  NUM_REQ  one-hot current grant (0 when none)
- busy  out  1  high in LOCK
- proto_err  out  NUM_REQ  sticky per-requester protocol error

## Operation
- Transfer: a flit moves when out_valid && out_ready in the same cycle. req_ready[i] = out_ready && grant[i], except in the drain case below.
- States: IDLE, LOCK. Registers: state, owner[PTR_W], rr_ptr[PTR_W], proto_err.
- IDLE:
  - Candidates are the requesters with req_valid[i] && req_is_header[i].
  - Winner is the first candidate found searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - grant is the one-hot winner, and its flit is forwarded combinationally.
  - On accepted header with is_tail=0: state<=LOCK, owner<=winner.
  - On accepted header with is_tail=1 (single-flit packet): stay IDLE, rr_ptr<=winner+1 mod NUM_REQ.
  - If the header is not accepted (out_ready=0), no state change. The winner may change next cycle.
- LOCK:
  - grant is one-hot at owner; only the owner's flit is forwarded.
  - Other requesters see req_ready=0.
  - On accepted flit with is_tail=1: state<=IDLE, rr_ptr<=owner+1 mod NUM_REQ.
- Drain: in IDLE, a requester with req_valid=1 and req_is_header=0 is not a candidate. It gets req_ready=1, its flit is discarded, and proto_err[i]<=1.
- Header while locked: owner presents is_header=1 in LOCK. The flit is still forwarded and proto_err[owner]<=1. Packet continues until tail.
- Wrap: rr_ptr increments modulo NUM_REQ (owner NUM_REQ-1 -> 0).
- proto_err is cleared only by reset.

## Timing
- Datapath latency 0: out_* is a combinational function of inputs and registered state.
- Grant update: state/owner/rr_ptr change on the edge after the accepting cycle.
- A new packet's header may be accepted in the cycle immediately after the previous tail (no bubble).
- Reset (noc_rst=1 at an edge): state=IDLE, owner=0, rr_ptr=0, proto_err=0.
- While noc_rst=1: out_valid=0, req_ready=0, grant=0, busy=0.
- Reset mid-packet abandons the lock; the router side is also reset by the same signal.
- Simultaneous tail-accept and new header: the new header is arbitrated the next cycle using the updated rr_ptr.
- out_ready low: hold all state; valid flits must not be dropped; grant holds in LOCK.

## Test plan
- Single requester: req0 sends header/data/tail with out_ready=1 -> three transfers on consecutive cycles; grant=0001 throughout; rr_ptr=1 after the tail; busy high for cycles 2-3.
- Contention: all 4 requesters send 3-flit packets from reset -> output packet order req0, req1, req2, req3, req0...; no flit interleaving; each requester's req_ready=0 while another owns the port.
- Backpressure: out_ready toggles 1,0,0,1 during req2's packet -> flits are held and transferred in order; grant stays 0100; no loss or duplication.
- Single-flit packet: req1 header+tail in one flit while req3 also pending -> req1 accepted, state stays IDLE, rr_ptr=2, req3 granted the next cycle.
- Protocol errors: req2 sends a data flit in IDLE -> req_ready[2]=1, out_valid=0 for that flit, proto_err=0100. Owner req0 sends a second header in LOCK -> forwarded, proto_err=0101.
- Reset mid-packet: noc_rst asserted after req1's header -> next cycle grant=0, busy=0, rr_ptr=0; a req3 header afterwards is granted.

Source files
------------

// File: rtl/noc_local_inject_arbiter_if.sv
// Requester-side and router-side handshake bundle for the local injection arbiter.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

interface noc_local_inject_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = `Noc_Data_Width
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_flit;
  logic [NUM_REQ-1:0]        req_is_header;
  logic [NUM_REQ-1:0]        req_is_tail;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_flit;
  logic                      out_is_header;
  logic                      out_is_tail;

  // Arbiter view: consumes requester flits, drives the router local port.
  modport master (
    input  req_valid, req_flit, req_is_header, req_is_tail, out_ready,
    output req_ready, out_valid, out_flit, out_is_header, out_is_tail
  );

  // Environment view: requesters and router.
  modport slave (
    output req_valid, req_flit, req_is_header, req_is_tail, out_ready,
    input  req_ready, out_valid, out_flit, out_is_header, out_is_tail
  );
endinterface

// File: rtl/noc_local_inject_arbiter.sv
// Packet-level round-robin arbiter sharing one NoC local injection port among
// NUM_REQ requesters; zero-latency datapath, registered IDLE/LOCK arbitration.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_local_inject_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2,
  parameter int DATA_W  = `Noc_Data_Width
) (
  input  logic                       noc_clk,
  input  logic                       noc_rst,
  noc_local_inject_arbiter_if.master bus,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic [NUM_REQ-1:0]         proto_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]         state;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   sel;
  logic               sel_vld;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] drain;
  logic               xfer;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) >= NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  // First set bit of c at or above start, wrapping modulo NUM_REQ.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] c,
                                               input logic [PTR_W-1:0]   start);
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] win;
    logic             found;
    idx   = start;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && c[idx]) begin
        win   = idx;
        found = 1'b1;
      end
      idx = ptr_inc(idx);
    end
    return win;
  endfunction

  always_comb begin
    cand    = '0;
    drain   = '0;
    sel     = '0;
    sel_vld = 1'b0;
    if (!noc_rst) begin
      if (state == ST_LOCK) begin
        sel     = owner;
        sel_vld = 1'b1;
      end else begin
        cand    = bus.req_valid & bus.req_is_header;
        // Headerless flits in IDLE belong to no packet: swallow and flag them.
        drain   = bus.req_valid & ~bus.req_is_header;
        sel     = rr_pick(cand, rr_ptr);
        sel_vld = |cand;
      end
    end
    grant             = sel_vld ? (NUM_REQ'(1) << sel) : '0;
    bus.out_valid     = sel_vld && bus.req_valid[sel];
    bus.out_flit      = bus.req_flit[sel*DATA_W +: DATA_W];
    bus.out_is_header = bus.req_is_header[sel];
    bus.out_is_tail   = bus.req_is_tail[sel];
    bus.req_ready     = ({NUM_REQ{bus.out_ready}} & grant) | drain;
  end

  assign xfer = bus.out_valid && bus.out_ready;
  assign busy = !noc_rst && (state == ST_LOCK);

  // Arbitration state boundary
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      proto_err <= '0;
    end else begin
      proto_err <= proto_err | drain;
      if (state == ST_IDLE) begin
        if (xfer) begin
          if (bus.out_is_tail) begin
            rr_ptr <= ptr_inc(sel);
          end else begin
            state <= ST_LOCK;
            owner <= sel;
          end
        end
      end else begin
        if (bus.req_valid[owner] && bus.req_is_header[owner]) proto_err[owner] <= 1'b1;
        if (xfer && bus.out_is_tail) begin
          state  <= ST_IDLE;
          rr_ptr <= ptr_inc(owner);
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// Directed self-checking bench for noc_local_inject_arbiter (4 requesters, 32-bit flits).
module tb_noc_local_inject_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] grant;
  logic          busy;
  logic [NR-1:0] proto_err;
  int            n_cmp = 0;
  int            n_err = 0;

  noc_local_inject_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  noc_local_inject_arbiter #(.NUM_REQ(NR), .PTR_W(2), .DATA_W(DW)) dut (
    .noc_clk   (clk),
    .noc_rst   (rst),
    .bus       (bus),
    .grant     (grant),
    .busy      (busy),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic h, input logic t,
                       input logic [31:0] f);
    bus.req_valid[i]         = v;
    bus.req_is_header[i]     = h;
    bus.req_is_tail[i]       = t;
    bus.req_flit[i*DW +: DW] = f;
  endtask

  task automatic clr_all();
    for (int i = 0; i < NR; i++) drive(i, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_all();
    tick();
    rst = 1'b0;
  endtask

  int idx[NR];
  int pk[NR];
  int exp_own[5] = '{0, 1, 2, 3, 0};
  int o;
  int bp_rdy[5] = '{1, 0, 0, 1, 1};
  int bp_i;

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b0;
    clr_all();
    tick();
    // Outputs gated while reset is held, even with a pending header
    drive(0, 1'b1, 1'b1, 1'b0, 32'h000000A0);
    drive(2, 1'b1, 1'b0, 1'b0, 32'h000000C0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    rst = 1'b0;
    clr_all();

    // Single requester: header, data, tail
    drive(0, 1'b1, 1'b1, 1'b0, 32'h000000A0);
    @(negedge clk);
    chk("s_hdr_grant", 32'(grant), 32'h1);
    chk("s_hdr_ready", 32'(bus.req_ready), 32'h1);
    chk("s_hdr_flit", bus.out_flit, 32'h000000A0);
    chk("s_hdr_busy", 32'(busy), 32'd0);
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 32'h000000A1);
    @(negedge clk);
    chk("s_dat_grant", 32'(grant), 32'h1);
    chk("s_dat_busy", 32'(busy), 32'd1);
    chk("s_dat_flit", bus.out_flit, 32'h000000A1);
    chk("s_dat_valid", 32'(bus.out_valid), 32'd1);
    tick();
    drive(0, 1'b1, 1'b0, 1'b1, 32'h000000A2);
    @(negedge clk);
    chk("s_tl_busy", 32'(busy), 32'd1);
    chk("s_tl_tail", 32'(bus.out_is_tail), 32'd1);
    chk("s_tl_ready", 32'(bus.req_ready), 32'h1);
    tick();
    clr_all();
    @(negedge clk);
    chk("s_end_busy", 32'(busy), 32'd0);
    chk("s_end_rr_ptr", 32'(dut.rr_ptr), 32'd1);
    chk("s_end_grant", 32'(grant), 32'd0);
    tick();

    // Contention: all four requesters stream 3-flit packets
    do_reset();
    for (int i = 0; i < NR; i++) begin
      idx[i] = 0;
      pk[i]  = 0;
    end
    for (int p = 0; p < 5; p++) begin
      o = exp_own[p];
      for (int f = 0; f < 3; f++) begin
        for (int i = 0; i < NR; i++)
          drive(i, 1'b1, idx[i] == 0, idx[i] == 2, 32'((i << 8) | (pk[i] << 4) | idx[i]));
        @(negedge clk);
        chk("c_grant", 32'(grant), 32'(1) << o);
        chk("c_ready", 32'(bus.req_ready), 32'(1) << o);
        chk("c_flit", bus.out_flit, 32'((o << 8) | (pk[o] << 4) | f));
        chk("c_tail", 32'(bus.out_is_tail), 32'(f == 2));
        chk("c_busy", 32'(busy), 32'(f != 0));
        tick();
        idx[o]++;
        if (idx[o] == 3) begin
          idx[o] = 0;
          pk[o]++;
        end
      end
    end
    clr_all();
    @(negedge clk);
    chk("c_end_rr_ptr", 32'(dut.rr_ptr), 32'd1);
    tick();

    // Backpressure during req2's packet: out_ready 1,0,0,1 then 1
    bp_i = 0;
    for (int c = 0; c < 5; c++) begin
      bus.out_ready = bp_rdy[c][0];
      drive(2, 1'b1, bp_i == 0, bp_i == 2, 32'h00000200 | 32'(bp_i));
      @(negedge clk);
      chk("bp_grant", 32'(grant), 32'h4);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_flit", bus.out_flit, 32'h00000200 | 32'(bp_i));
      chk("bp_ready", 32'(bus.req_ready), bp_rdy[c] != 0 ? 32'h4 : 32'h0);
      tick();
      if (bp_rdy[c] != 0) bp_i++;
    end
    clr_all();
    @(negedge clk);
    chk("bp_end_busy", 32'(busy), 32'd0);
    chk("bp_end_rr_ptr", 32'(dut.rr_ptr), 32'd3);
    tick();

    // Single-flit packet from req1 while req3 waits
    do_reset();
    drive(1, 1'b1, 1'b1, 1'b1, 32'h00000110);
    drive(3, 1'b1, 1'b1, 1'b1, 32'h00000310);
    @(negedge clk);
    chk("sf_grant1", 32'(grant), 32'h2);
    chk("sf_ready1", 32'(bus.req_ready), 32'h2);
    chk("sf_flit1", bus.out_flit, 32'h00000110);
    tick();
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("sf_busy", 32'(busy), 32'd0);
    chk("sf_rr_ptr", 32'(dut.rr_ptr), 32'd2);
    chk("sf_grant3", 32'(grant), 32'h8);
    chk("sf_flit3", bus.out_flit, 32'h00000310);
    tick();
    clr_all();
    @(negedge clk);
    chk("sf_wrap_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    tick();

    // Protocol errors: data flit in IDLE, then a second header in LOCK
    drive(2, 1'b1, 1'b0, 1'b0, 32'h000002EE);
    @(negedge clk);
    chk("pe_drain_ready", 32'(bus.req_ready), 32'h4);
    chk("pe_drain_valid", 32'(bus.out_valid), 32'd0);
    chk("pe_drain_grant", 32'(grant), 32'd0);
    tick();
    clr_all();
    chk("pe_err1", 32'(proto_err), 32'h4);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h00000050);
    tick();
    drive(0, 1'b1, 1'b1, 1'b0, 32'h00000051);
    @(negedge clk);
    chk("pe_lock_valid", 32'(bus.out_valid), 32'd1);
    chk("pe_lock_hdr", 32'(bus.out_is_header), 32'd1);
    chk("pe_lock_grant", 32'(grant), 32'h1);
    tick();
    chk("pe_err2", 32'(proto_err), 32'h5);
    drive(0, 1'b1, 1'b0, 1'b1, 32'h00000052);
    @(negedge clk);
    chk("pe_tail_busy", 32'(busy), 32'd1);
    tick();
    clr_all();
    @(negedge clk);
    chk("pe_end_busy", 32'(busy), 32'd0);
    chk("pe_err_sticky", 32'(proto_err), 32'h5);
    tick();

    // Reset mid-packet abandons req1's lock
    drive(1, 1'b1, 1'b1, 1'b0, 32'h00000170);
    tick();
    chk("rm_locked", 32'(busy), 32'd1);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h00000171);
    rst = 1'b1;
    @(negedge clk);
    chk("rm_rst_grant", 32'(grant), 32'd0);
    chk("rm_rst_valid", 32'(bus.out_valid), 32'd0);
    tick();
    rst = 1'b0;
    clr_all();
    @(negedge clk);
    chk("rm_grant", 32'(grant), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    chk("rm_proto_err", 32'(proto_err), 32'd0);
    tick();
    drive(3, 1'b1, 1'b1, 1'b0, 32'h00000380);
    @(negedge clk);
    chk("rm_new_grant", 32'(grant), 32'h8);
    chk("rm_new_flit", bus.out_flit, 32'h00000380);
    tick();
    clr_all();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
